// File: rtl/vga_ctrl_640x480.sv
// VGA 640x480@60 timing generator: free-running pixel/line counters decoded into
// syncs, blank-not and active coordinates, with colour gated to the active window.
module vga_ctrl_640x480 #(
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_ACT_ST  = 144,
   parameter int unsigned H_ACT_END = 784,
   parameter int unsigned H_TOTAL   = 800,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_ACT_ST  = 35,
   parameter int unsigned V_ACT_END = 515,
   parameter int unsigned V_TOTAL   = 525
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic [23:0] vga_data,
   output logic [9:0]  h_addr,
   output logic [9:0]  v_addr,
   output logic        hsync,
   output logic        vsync,
   output logic        valid,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b
);

   localparam logic [9:0] H_SYNC_C    = 10'(H_SYNC);
   localparam logic [9:0] H_ACT_ST_C  = 10'(H_ACT_ST);
   localparam logic [9:0] H_ACT_END_C = 10'(H_ACT_END);
   localparam logic [9:0] H_LAST_C    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_SYNC_C    = 10'(V_SYNC);
   localparam logic [9:0] V_ACT_ST_C  = 10'(V_ACT_ST);
   localparam logic [9:0] V_ACT_END_C = 10'(V_ACT_END);
   localparam logic [9:0] V_LAST_C    = 10'(V_TOTAL - 1);

   logic [9:0] x_cnt_q, x_cnt_d;
   logic [9:0] y_cnt_q, y_cnt_d;
   logic       h_valid, v_valid, act;

   always_comb begin
      x_cnt_d = x_cnt_q + 10'd1;
      y_cnt_d = y_cnt_q;
      if (x_cnt_q == H_LAST_C) begin
         x_cnt_d = '0;
         y_cnt_d = (y_cnt_q == V_LAST_C) ? '0 : y_cnt_q + 10'd1;
      end
   end

   // Reset wins over counting so a mid-frame reset restarts the frame cleanly.
   always_ff @(posedge pclk) begin
      if (!reset) begin
         x_cnt_q <= '0;
         y_cnt_q <= '0;
      end else begin
         x_cnt_q <= x_cnt_d;
         y_cnt_q <= y_cnt_d;
      end
   end

   always_comb begin
      hsync   = (x_cnt_q >= H_SYNC_C);
      vsync   = (y_cnt_q >= V_SYNC_C);
      h_valid = (x_cnt_q >= H_ACT_ST_C) && (x_cnt_q < H_ACT_END_C);
      v_valid = (y_cnt_q >= V_ACT_ST_C) && (y_cnt_q < V_ACT_END_C);
      act     = h_valid && v_valid;
      valid   = act;
      h_addr  = h_valid ? (x_cnt_q - H_ACT_ST_C) : '0;
      v_addr  = v_valid ? (y_cnt_q - V_ACT_ST_C) : '0;
      // Upstream returns vga_data combinationally from h_addr/v_addr in this same cycle.
      {vga_r, vga_g, vga_b} = act ? vga_data : 24'h0;
   end

endmodule

// File: tb/tb_vga_ctrl_640x480.sv
// Bench for vga_ctrl_640x480: full-size instance for line/sync timing and the top of
// the active window, plus a shrunken-timing instance to exercise whole frames quickly.
module tb_vga_ctrl_640x480;

   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       vl;
      logic [9:0] ha;
      logic [9:0] va;
      logic [23:0] rgb;
   } obs_t;

   typedef struct {
      int hs, hst, hen, htot, vs, vst, ven, vtot;
   } tim_t;

   typedef struct {
      int   inst;
      int   x;
      int   y;
      obs_t e;
   } cp_t;

   logic        rst_a, rst_b, pat_a, pat_b;
   logic [23:0] const_a, const_b, data_a, data_b;
   logic [9:0]  ha_a, va_a, ha_b, va_b;
   logic        hs_a, vs_a, vl_a, hs_b, vs_b, vl_b;
   logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
   obs_t        act_a, act_b;

   // Upstream stand-in: colour either constant or derived from the published coordinate.
   assign data_a = pat_a ? {ha_a[9:2], va_a[7:0], 8'hC3} : const_a;
   assign data_b = pat_b ? {ha_b[9:2], va_b[7:0], 8'hC3} : const_b;
   assign act_a  = {hs_a, vs_a, vl_a, ha_a, va_a, r_a, g_a, b_a};
   assign act_b  = {hs_b, vs_b, vl_b, ha_b, va_b, r_b, g_b, b_b};

   vga_ctrl_640x480 dut_a (
      .pclk(pclk), .reset(rst_a), .vga_data(data_a),
      .h_addr(ha_a), .v_addr(va_a), .hsync(hs_a), .vsync(vs_a), .valid(vl_a),
      .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
   );

   vga_ctrl_640x480 #(
      .H_SYNC(4), .H_ACT_ST(6), .H_ACT_END(14), .H_TOTAL(16),
      .V_SYNC(2), .V_ACT_ST(3), .V_ACT_END(9), .V_TOTAL(10)
   ) dut_b (
      .pclk(pclk), .reset(rst_b), .vga_data(data_b),
      .h_addr(ha_b), .v_addr(va_b), .hsync(hs_b), .vsync(vs_b), .valid(vl_b),
      .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   tim_t tim [2];
   int   mx [2];
   int   my [2];
   logic en [2];
   obs_t q_a [$];
   obs_t q_b [$];
   cp_t  tbl [$];
   int   hits [32];
   int   low_run [4];
   int   gap [4];
   logic prev [4];
   logic has_fall [4];
   int   vcnt_b;
   int   vline_a;
   logic mid_b_done;

   function automatic obs_t model(tim_t t, int x, int y, logic [23:0] cdat, logic pat);
      obs_t o;
      logic hv, vv;
      hv    = (x >= t.hst) && (x < t.hen);
      vv    = (y >= t.vst) && (y < t.ven);
      o.hs  = (x >= t.hs);
      o.vs  = (y >= t.vs);
      o.vl  = hv && vv;
      o.ha  = hv ? 10'(x - t.hst) : 10'd0;
      o.va  = vv ? 10'(y - t.vst) : 10'd0;
      o.rgb = !o.vl ? 24'h0 : (pat ? {o.ha[9:2], o.va[7:0], 8'hC3} : cdat);
      return o;
   endfunction

   task automatic add_cp(int inst, int x, int y, logic hs, logic vs, logic vl,
                         int ha, int va, logic [23:0] rgb);
      cp_t c;
      c.inst   = inst;
      c.x      = x;
      c.y      = y;
      c.e.hs   = hs;
      c.e.vs   = vs;
      c.e.vl   = vl;
      c.e.ha   = 10'(ha);
      c.e.va   = 10'(va);
      c.e.rgb  = rgb;
      tbl.push_back(c);
   endtask

   task automatic chk(string nm, obs_t got, obs_t exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got hs=%0b vs=%0b valid=%0b h=%0d v=%0d rgb=%06h, want hs=%0b vs=%0b valid=%0b h=%0d v=%0d rgb=%06h",
                  nm, got.hs, got.vs, got.vl, got.ha, got.va, got.rgb,
                  exp.hs, exp.vs, exp.vl, exp.ha, exp.va, exp.rgb);
      end
   endtask

   task automatic chk_int(string nm, int got, int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", nm, got, exp);
      end
   endtask

   // Pulse-width and period tracking on an active-low sync line, sampled once per cycle.
   task automatic track(int id, string nm, logic s, int e_low, int e_per);
      gap[id]++;
      if (prev[id] && !s) begin
         if (has_fall[id]) chk_int({nm, "_period"}, gap[id], e_per);
         if (id == 3 && has_fall[id]) chk_int("b_valid_per_frame", vcnt_b, 48);
         if (id == 3) vcnt_b = 0;
         gap[id]      = 0;
         has_fall[id] = 1'b1;
      end
      if (!s) low_run[id]++;
      else if (low_run[id] != 0) begin
         chk_int({nm, "_low"}, low_run[id], e_low);
         low_run[id] = 0;
      end
      prev[id] = s;
   endtask

   task automatic clr_track(int id);
      low_run[id]  = 0;
      gap[id]      = 0;
      prev[id]     = 1'b0;
      has_fall[id] = 1'b0;
   endtask

   task automatic advance(int i);
      if (mx[i] == tim[i].htot - 1) begin
         mx[i] = 0;
         my[i] = (my[i] == tim[i].vtot - 1) ? 0 : my[i] + 1;
      end else begin
         mx[i] = mx[i] + 1;
      end
   endtask

   task automatic cycle();
      obs_t ea, eb;
      q_a.push_back(model(tim[0], mx[0], my[0], const_a, pat_a));
      q_b.push_back(model(tim[1], mx[1], my[1], const_b, pat_b));
      @(negedge pclk);
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      if (en[0]) begin
         chk($sformatf("a x=%0d y=%0d", mx[0], my[0]), act_a, ea);
         track(0, "a_hsync", hs_a, 96, 800);
         track(1, "a_vsync", vs_a, 1600, 420000);
         if (my[0] == 35 && vl_a) vline_a++;
      end
      if (en[1]) begin
         chk($sformatf("b x=%0d y=%0d", mx[1], my[1]), act_b, eb);
         if (vl_b) vcnt_b++;
         track(2, "b_hsync", hs_b, 4, 16);
         track(3, "b_vsync", vs_b, 32, 160);
      end
      for (int k = 0; k < tbl.size(); k++) begin
         if (en[tbl[k].inst] && tbl[k].x == mx[tbl[k].inst] && tbl[k].y == my[tbl[k].inst]) begin
            hits[k]++;
            chk($sformatf("cp%0d inst=%0d x=%0d y=%0d", k, tbl[k].inst, tbl[k].x, tbl[k].y),
                (tbl[k].inst == 0) ? act_a : act_b, tbl[k].e);
         end
      end
      @(posedge pclk);
      if (!rst_a) begin
         mx[0] = 0; my[0] = 0; en[0] = 1'b1;
         clr_track(0); clr_track(1);
      end else if (en[0]) advance(0);
      if (!rst_b) begin
         mx[1] = 0; my[1] = 0; en[1] = 1'b1;
         clr_track(2); clr_track(3);
         vcnt_b = 0;
      end else if (en[1]) advance(1);
      #1;
   endtask

   initial begin
      tim[0] = '{96, 144, 784, 800, 2, 35, 515, 525};
      tim[1] = '{4, 6, 14, 16, 2, 3, 9, 10};
      for (int k = 0; k < 32; k++) hits[k] = 0;
      for (int k = 0; k < 4; k++) clr_track(k);
      mx[0] = 0; my[0] = 0; mx[1] = 0; my[1] = 0;
      en[0] = 1'b0; en[1] = 1'b0;
      vcnt_b = 0; vline_a = 0; mid_b_done = 1'b0;

      //     inst x    y   hs vs vl  h    v  rgb
      add_cp(0,   0,   0, 0, 0, 0,   0,  0, 24'h000000);
      add_cp(0,  95,   0, 0, 0, 0,   0,  0, 24'h000000);
      add_cp(0,  96,   0, 1, 0, 0,   0,  0, 24'h000000);
      add_cp(0, 799,   1, 1, 0, 0,   0,  0, 24'h000000);
      add_cp(0,   0,   2, 0, 1, 0,   0,  0, 24'h000000);
      add_cp(0, 200,  20, 1, 1, 0,  56,  0, 24'h000000);
      add_cp(0, 500,  34, 1, 1, 0, 356,  0, 24'h000000);
      add_cp(0, 143,  35, 1, 1, 0,   0,  0, 24'h000000);
      add_cp(0, 144,  35, 1, 1, 1,   0,  0, 24'hFF8001);
      add_cp(0, 145,  35, 1, 1, 1,   1,  0, 24'hFF8001);
      add_cp(0, 783,  35, 1, 1, 1, 639,  0, 24'hFF8001);
      add_cp(0, 784,  35, 1, 1, 0,   0,  0, 24'h000000);
      add_cp(1,   0,   0, 0, 0, 0,   0,  0, 24'h000000);
      add_cp(1,   3,   1, 0, 0, 0,   0,  0, 24'h000000);
      add_cp(1,   4,   2, 1, 1, 0,   0,  0, 24'h000000);
      add_cp(1,   6,   3, 1, 1, 1,   0,  0, 24'h0000C3);
      add_cp(1,  13,   8, 1, 1, 1,   7,  5, 24'h0105C3);
      add_cp(1,  14,   8, 1, 1, 0,   0,  5, 24'h000000);
      add_cp(1,  10,   9, 1, 1, 0,   4,  0, 24'h000000);
      add_cp(1,  15,   9, 1, 1, 0,   0,  0, 24'h000000);

      rst_a = 1'b0; rst_b = 1'b0;
      const_a = 24'hFF8001; const_b = 24'h123456;
      pat_a = 1'b0; pat_b = 1'b1;
      repeat (3) cycle();
      rst_a = 1'b1; rst_b = 1'b1;

      // Scan to the start of line 36; the small instance runs many frames meanwhile.
      for (int i = 0; i < 28800; i++) begin
         rst_b = 1'b1;
         if (i > 3000 && !mid_b_done && mx[1] == 8 && my[1] == 5) begin
            rst_b      = 1'b0;
            mid_b_done = 1'b1;
         end
         cycle();
      end
      rst_b = 1'b1;
      chk_int("a_line35_valid_count", vline_a, 640);

      // Line 36 with colour looked up from the published coordinate.
      pat_a = 1'b1;
      repeat (800) cycle();
      pat_a = 1'b0;

      // Mid-frame reset of the full-size instance, then re-check sync widths.
      repeat (300) cycle();
      rst_a = 1'b0;
      repeat (2) cycle();
      rst_a = 1'b1;
      repeat (2000) cycle();

      for (int k = 0; k < tbl.size(); k++)
         chk_int($sformatf("cp%0d_reached", k), int'(hits[k] > 0), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
